// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: SPI-mode SD command sequencer with CRC7 framing, response capture, R1b busy wait and retry
module sd_cmd_seq #(
  parameter int PRE_CLKS = 8,
  parameter int RESP_W = 40,
  parameter int TIMEOUT = 2000,
  parameter int MAX_RETRY = 2
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic [5:0] index,
  input logic [31:0] argument,
  input logic resp_long,
  input logic wait_busy,
  output logic busy,
  output logic finish,
  output logic timeout_err,
  output logic [3:0] retries_used,
  output logic [RESP_W-1:0] response,
  output logic DI,
  input logic DO
);
  typedef enum logic [2:0] {IDLE, PRE, SEND, WAIT_RESP, RECV, WAIT_BUSY, DONE} state_t;
  localparam int M0 = PRE_CLKS > TIMEOUT ? PRE_CLKS : TIMEOUT;
  localparam int M1 = M0 > RESP_W ? M0 : RESP_W;
  localparam int CW = $clog2((M1 > 48 ? M1 : 48) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [5:0] idx_q;
  logic [31:0] arg_q;
  logic long_q, wb_q;
  logic [RESP_W-3:0] sr;
  logic [39:0] msg;
  logic [6:0] crc;
  logic [47:0] frame;
  logic [5:0] bit_sel;
  logic pre_end, send_end, to_end, rx_end, can_retry;
  assign msg = {2'b01, idx_q, arg_q};
  assign frame = {msg, crc, 1'b1};
  assign bit_sel = 6'd47 - cnt[5:0];
  assign pre_end = cnt == CW'(PRE_CLKS - 1);
  assign send_end = cnt == CW'(47);
  assign to_end = cnt == CW'(TIMEOUT - 1);
  assign rx_end = cnt == (long_q ? CW'(RESP_W - 1) : CW'(7));
  assign can_retry = retries_used < 4'(MAX_RETRY);
  assign busy = state != IDLE;
  assign finish = state == DONE;
  assign DI = (state == SEND) ? frame[bit_sel] : 1'b1;
  always_comb begin
    crc = '0;
    for (int k = 39; k >= 0; k--) crc = {crc[5:0], 1'b0} ^ ((crc[6] ^ msg[k]) ? 7'h09 : 7'h00);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? PRE : IDLE;
      PRE: state_n = pre_end ? SEND : PRE;
      SEND: state_n = send_end ? WAIT_RESP : SEND;
      WAIT_RESP: state_n = !DO ? RECV : !to_end ? WAIT_RESP : can_retry ? PRE : DONE;
      RECV: state_n = !rx_end ? RECV : wb_q ? WAIT_BUSY : DONE;
      WAIT_BUSY: state_n = (DO || to_end) ? DONE : WAIT_BUSY;
      DONE: state_n = start ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx_q <= '0;
      arg_q <= '0;
      long_q <= 1'b0;
      wb_q <= 1'b0;
      sr <= '0;
      response <= '0;
      timeout_err <= 1'b0;
      retries_used <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == WAIT_RESP && !DO) ? CW'(1) : (state_n != state || state == IDLE || state == DONE) ? '0 : cnt + CW'(1);
      sr <= (state == RECV) ? {sr[RESP_W-4:0], DO} : '0;
      if (state == IDLE && start) begin
        idx_q <= index;
        arg_q <= argument;
        long_q <= resp_long;
        wb_q <= wait_busy;
        retries_used <= '0;
        timeout_err <= 1'b0;
      end
      if (state == WAIT_RESP && DO && to_end) begin
        if (can_retry) retries_used <= retries_used + 4'd1;
        else begin
          response <= '1;
          timeout_err <= 1'b1;
        end
      end
      if (state == RECV && rx_end) response <= {1'b0, sr, DO};
      if (state == WAIT_BUSY && !DO && to_end) timeout_err <= 1'b1;
    end
  end
endmodule
